// File: rtl/accelerator_lstm_sequencer_pkg.sv
// accelerator_lstm_sequencer_pkg
// Shared definitions for the LSTM weight/bias/input load sequencer.
//   DEFAULT_DATA_SIZE    : default data and size word width
//   DEFAULT_CONTROL_SIZE : default CHANNEL width
//   DEFAULT_GATES        : default number of gate channels per cell
//   state_t              : sequencer FSM states (LOAD_P exists only when
//                          ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN is defined)
package accelerator_lstm_sequencer_pkg;

   localparam int unsigned DEFAULT_DATA_SIZE    = 64;
   localparam int unsigned DEFAULT_CONTROL_SIZE = 4;
   localparam int unsigned DEFAULT_GATES        = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_B,
`ifdef ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN
      LOAD_P,
`endif
      LOAD_X,
      DONE
   } state_t;

endpackage

// File: rtl/accelerator_lstm_index_counter.sv
// accelerator_lstm_index_counter
// Three-level nested index counter: i fastest, j middle, g slowest.
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : advance by one element
//   clear           : synchronous return of all indices to 0
//   lim_i/j/g       : element counts per level (must be non-zero while enabled)
//   idx_i/j/g       : current indices
//   wrap_i/j/g      : level is on its last element; wrap_g marks the final
//                     element of the whole nest
module accelerator_lstm_index_counter #(
   parameter int unsigned IDX_W = 64,
   parameter int unsigned G_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic [IDX_W-1:0] lim_i,
   input  logic [IDX_W-1:0] lim_j,
   input  logic [G_W:0]     lim_g,
   output logic [IDX_W-1:0] idx_i,
   output logic [IDX_W-1:0] idx_j,
   output logic [G_W-1:0]   idx_g,
   output logic             wrap_i,
   output logic             wrap_j,
   output logic             wrap_g
);

   localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
   localparam logic [G_W:0]     G_ONE   = (G_W + 1)'(1);
   localparam logic [G_W-1:0]   G_STEP  = G_W'(1);

   // Compare against limit-1 so an index never has to reach the limit value;
   // this keeps sizes up to 2**IDX_W-1 free of overflow.
   always_comb begin
      wrap_i = (idx_i == lim_i - ONE);
      wrap_j = wrap_i && (idx_j == lim_j - ONE);
      wrap_g = wrap_j && ({1'b0, idx_g} == lim_g - G_ONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_i <= '0;
         idx_j <= '0;
         idx_g <= '0;
      end else if (clear) begin
         idx_i <= '0;
         idx_j <= '0;
         idx_g <= '0;
      end else if (enable) begin
         idx_i <= wrap_i ? '0 : idx_i + ONE;
         if (wrap_i) begin
            idx_j <= wrap_j ? '0 : idx_j + ONE;
         end
         if (wrap_j) begin
            idx_g <= wrap_g ? '0 : idx_g + G_STEP;
         end
      end
   end

endmodule

// File: rtl/accelerator_lstm_sequencer.sv
// accelerator_lstm_sequencer
// Streams LSTM parameters into gate channels: GATES*L*X weights, GATES*L
// biases, optionally (GATES-1)*L peepholes, then X inputs.
// Optional feature macro: ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN (adds LOAD_P
// and the P_OUT_ENABLE port).
//   CLK, RST                : clock, asynchronous active-high reset
//   START                   : start request (sampled in IDLE only)
//   SIZE_X_IN, SIZE_L_IN    : input length X, hidden length L
//   DATA_IN / _VALID / _READY : element stream handshake
//   DATA_OUT, CHANNEL       : registered accepted element and its gate index
//   W_OUT_X_ENABLE          : weight element strobe
//   W_OUT_L_ENABLE          : weight row-end strobe
//   B_OUT_ENABLE            : bias element strobe
//   X_OUT_ENABLE            : input element strobe
//   P_OUT_ENABLE            : peephole element strobe (macro only)
//   READY                   : completion pulse, with the last X_OUT_ENABLE
//   ERROR                   : pulse when a zero size is requested
module accelerator_lstm_sequencer
   import accelerator_lstm_sequencer_pkg::*;
#(
   parameter int unsigned DATA_SIZE    = DEFAULT_DATA_SIZE,
   parameter int unsigned CONTROL_SIZE = DEFAULT_CONTROL_SIZE,
   parameter int unsigned GATES        = DEFAULT_GATES
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   output logic                    ERROR,
   input  logic [DATA_SIZE-1:0]    SIZE_X_IN,
   input  logic [DATA_SIZE-1:0]    SIZE_L_IN,
   input  logic [DATA_SIZE-1:0]    DATA_IN,
   input  logic                    DATA_IN_VALID,
   output logic                    DATA_IN_READY,
   output logic [DATA_SIZE-1:0]    DATA_OUT,
   output logic [CONTROL_SIZE-1:0] CHANNEL,
   output logic                    W_OUT_X_ENABLE,
   output logic                    W_OUT_L_ENABLE,
   output logic                    B_OUT_ENABLE,
   output logic                    X_OUT_ENABLE
`ifdef ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN
   ,
   output logic                    P_OUT_ENABLE
`endif
);

   localparam logic [DATA_SIZE-1:0]  ONE      = DATA_SIZE'(1);
   localparam logic [CONTROL_SIZE:0] GATE_LIM = (CONTROL_SIZE + 1)'(GATES);
   localparam logic [CONTROL_SIZE:0] G_ONE    = (CONTROL_SIZE + 1)'(1);

`ifdef ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN
   // A single-gate cell has no peephole elements, so LOAD_P is skipped.
   localparam state_t AFTER_B = (GATES > 1) ? LOAD_P : LOAD_X;
`else
   localparam state_t AFTER_B = LOAD_X;
`endif

   state_t                  state;
   logic [DATA_SIZE-1:0]    size_x;
   logic [DATA_SIZE-1:0]    size_l;
   logic                    xfer;
   logic [DATA_SIZE-1:0]    lim_i;
   logic [DATA_SIZE-1:0]    lim_j;
   logic [CONTROL_SIZE:0]   lim_g;
   logic [DATA_SIZE-1:0]    idx_i;
   logic [DATA_SIZE-1:0]    idx_j;
   logic [CONTROL_SIZE-1:0] idx_g;
   logic                    wrap_i;
   logic                    wrap_j;
   logic                    wrap_g;
   logic                    unused_idx;

   assign xfer = DATA_IN_VALID && DATA_IN_READY;

   // Every load phase reuses the same nest; unused levels get a limit of 1
   // so wrap_g always marks the final element of the current phase.
   always_comb begin
      lim_i = size_x;
      lim_j = size_l;
      lim_g = GATE_LIM;
      case (state)
         LOAD_B: lim_i = ONE;
`ifdef ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN
         LOAD_P: begin
            lim_i = ONE;
            lim_g = GATE_LIM - G_ONE;
         end
`endif
         LOAD_X: begin
            lim_j = ONE;
            lim_g = G_ONE;
         end
         default: ;
      endcase
   end

   accelerator_lstm_index_counter #(
      .IDX_W (DATA_SIZE),
      .G_W   (CONTROL_SIZE)
   ) u_index_counter (
      .clk    (CLK),
      .rst    (RST),
      .enable (xfer),
      .clear  (state == IDLE),
      .lim_i  (lim_i),
      .lim_j  (lim_j),
      .lim_g  (lim_g),
      .idx_i  (idx_i),
      .idx_j  (idx_j),
      .idx_g  (idx_g),
      .wrap_i (wrap_i),
      .wrap_j (wrap_j),
      .wrap_g (wrap_g)
   );

   // Only the wrap flags and the gate index drive the sequencer.
   assign unused_idx = ^{idx_i, idx_j, wrap_j};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state          <= IDLE;
         size_x         <= '0;
         size_l         <= '0;
         READY          <= 1'b0;
         ERROR          <= 1'b0;
         DATA_IN_READY  <= 1'b0;
         DATA_OUT       <= '0;
         CHANNEL        <= '0;
         W_OUT_X_ENABLE <= 1'b0;
         W_OUT_L_ENABLE <= 1'b0;
         B_OUT_ENABLE   <= 1'b0;
         X_OUT_ENABLE   <= 1'b0;
`ifdef ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN
         P_OUT_ENABLE   <= 1'b0;
`endif
      end else begin
         READY          <= 1'b0;
         ERROR          <= 1'b0;
         W_OUT_X_ENABLE <= 1'b0;
         W_OUT_L_ENABLE <= 1'b0;
         B_OUT_ENABLE   <= 1'b0;
         X_OUT_ENABLE   <= 1'b0;
`ifdef ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN
         P_OUT_ENABLE   <= 1'b0;
`endif
         if (xfer) begin
            DATA_OUT <= DATA_IN;
            CHANNEL  <= (state == LOAD_X) ? '0 : idx_g;
         end

         // DATA_IN_READY is registered alongside the state so it is high
         // exactly while a LOAD_* state is current.
         case (state)
            IDLE: begin
               if (START) begin
                  size_x <= SIZE_X_IN;
                  size_l <= SIZE_L_IN;
                  if ((SIZE_X_IN == '0) || (SIZE_L_IN == '0)) begin
                     ERROR <= 1'b1;
                  end else begin
                     state         <= LOAD_W;
                     DATA_IN_READY <= 1'b1;
                  end
               end
            end
            LOAD_W: begin
               if (xfer) begin
                  W_OUT_X_ENABLE <= 1'b1;
                  W_OUT_L_ENABLE <= wrap_i;
                  if (wrap_g) state <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (xfer) begin
                  B_OUT_ENABLE <= 1'b1;
                  if (wrap_g) state <= AFTER_B;
               end
            end
`ifdef ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN
            LOAD_P: begin
               if (xfer) begin
                  P_OUT_ENABLE <= 1'b1;
                  if (wrap_g) state <= LOAD_X;
               end
            end
`endif
            LOAD_X: begin
               if (xfer) begin
                  X_OUT_ENABLE <= 1'b1;
                  if (wrap_g) begin
                     state         <= DONE;
                     READY         <= 1'b1;
                     DATA_IN_READY <= 1'b0;
                  end
               end
            end
            DONE: state <= IDLE;
            default: begin
               state         <= IDLE;
               DATA_IN_READY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accelerator_lstm_sequencer.sv
// tb_accelerator_lstm_sequencer
// Scoreboard bench: the driver pushes one expected output record per accepted
// element, computed from the (X, L, element index) arithmetic of the load
// order; a negedge monitor pops and compares whenever a strobe appears.
module tb_accelerator_lstm_sequencer;

   localparam int G = 4;
`ifdef ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN
   localparam bit PEEP = 1'b1;
`else
   localparam bit PEEP = 1'b0;
`endif

   typedef struct {
      logic [63:0] data;
      logic [3:0]  ch;
      logic [4:0]  strb;   // {wx, wl, b, p, x}
      logic        rdy;
   } rec_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic        READY, ERROR;
   logic [63:0] SIZE_X_IN = '0, SIZE_L_IN = '0, DATA_IN = '0;
   logic        DATA_IN_VALID = 1'b0;
   logic        DATA_IN_READY;
   logic [63:0] DATA_OUT;
   logic [3:0]  CHANNEL;
   logic        W_OUT_X_ENABLE, W_OUT_L_ENABLE, B_OUT_ENABLE, X_OUT_ENABLE;
   logic        p_en;

   int          checks = 0, errors = 0, cyc = 0;
   int          n_wx = 0, n_wl = 0, n_b = 0, n_p = 0, n_x = 0, n_rdy = 0, n_err = 0;
   int          last_rdy_cyc = 0, prev_rdy_cyc = 0;
   rec_t        sb[$];

   accelerator_lstm_sequencer #(
      .DATA_SIZE    (64),
      .CONTROL_SIZE (4),
      .GATES        (G)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .START          (START),
      .READY          (READY),
      .ERROR          (ERROR),
      .SIZE_X_IN      (SIZE_X_IN),
      .SIZE_L_IN      (SIZE_L_IN),
      .DATA_IN        (DATA_IN),
      .DATA_IN_VALID  (DATA_IN_VALID),
      .DATA_IN_READY  (DATA_IN_READY),
      .DATA_OUT       (DATA_OUT),
      .CHANNEL        (CHANNEL),
      .W_OUT_X_ENABLE (W_OUT_X_ENABLE),
      .W_OUT_L_ENABLE (W_OUT_L_ENABLE),
      .B_OUT_ENABLE   (B_OUT_ENABLE),
      .X_OUT_ENABLE   (X_OUT_ENABLE)
`ifdef ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN
      ,
      .P_OUT_ENABLE   (p_en)
`endif
   );
`ifndef ACCELERATOR_LSTM_SEQUENCER_PEEPHOLE_EN
   assign p_en = 1'b0;
`endif

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int total_of(input int x, input int l);
      return G*l*x + G*l + (PEEP ? (G-1)*l : 0) + x;
   endfunction

   // Expected output for the k-th accepted element of a run: weights are
   // g-major, then j, then i; biases g-major then j; peepholes cover gates
   // 0..G-2; inputs always report channel 0.
   function automatic rec_t model(input int x, input int l, input int k, input logic [63:0] d);
      rec_t r;
      int nw = G*l*x, nb = G*l, np = PEEP ? (G-1)*l : 0;
      r.data = d; r.rdy = 1'b0; r.strb = '0; r.ch = '0;
      if (k < nw) begin
         r.ch = 4'(k / (l*x));
         r.strb[4] = 1'b1;
         r.strb[3] = ((k % x) == x-1);
      end else if (k < nw + nb) begin
         r.ch = 4'((k - nw) / l);
         r.strb[2] = 1'b1;
      end else if (k < nw + nb + np) begin
         r.ch = 4'((k - nw - nb) / l);
         r.strb[1] = 1'b1;
      end else begin
         r.strb[0] = 1'b1;
         r.rdy = (k == total_of(x, l) - 1);
      end
      return r;
   endfunction

   // Monitor
   always @(negedge CLK) begin
      logic [4:0] s;
      rec_t e;
      if (!RST) begin
         s = {W_OUT_X_ENABLE, W_OUT_L_ENABLE, B_OUT_ENABLE, p_en, X_OUT_ENABLE};
         if (s != '0) begin
            if (sb.size() == 0) begin
               check("unexpected_strobe", 64'(s), 64'd0);
            end else begin
               e = sb.pop_front();
               check("data_out", DATA_OUT, e.data);
               check("channel", 64'(CHANNEL), 64'(e.ch));
               check("strobes", 64'(s), 64'(e.strb));
               check("ready", 64'(READY), 64'(e.rdy));
            end
         end else if (READY) begin
            check("ready_without_strobe", 64'(READY), 64'd0);
         end
         n_wx += int'(W_OUT_X_ENABLE); n_wl += int'(W_OUT_L_ENABLE);
         n_b  += int'(B_OUT_ENABLE);   n_p  += int'(p_en);
         n_x  += int'(X_OUT_ENABLE);   n_err += int'(ERROR);
         if (READY) begin
            n_rdy++;
            prev_rdy_cyc = last_rdy_cyc;
            last_rdy_cyc = cyc;
         end
      end
   end

   task automatic issue_start(input int x, input int l);
      START = 1'b1; SIZE_X_IN = 64'(x); SIZE_L_IN = 64'(l);
      @(posedge CLK); #1;
      START = 1'b0; SIZE_X_IN = {$urandom, $urandom}; SIZE_L_IN = {$urandom, $urandom};
   endtask

   // mode 0: VALID always 1; mode 1: 1,0,1,0...; mode 2: random
   task automatic stream(input int x, input int l, input int mode, input int limit,
                         output int first_cyc);
      int k = 0, step = 0, budget = 4*limit + 40;
      logic v;
      first_cyc = 0;
      while (k < limit && budget > 0) begin
         v = (mode == 0) ? 1'b1 : (mode == 1) ? ((step % 2) == 0) : 1'($urandom_range(0, 1));
         DATA_IN_VALID = v;
         DATA_IN = {$urandom, $urandom};
         if (v && DATA_IN_READY) begin
            if (k == 0) first_cyc = cyc;
            sb.push_back(model(x, l, k % total_of(x, l), DATA_IN));
            k++;
         end
         @(posedge CLK); #1;
         step++; budget--;
      end
      DATA_IN_VALID = 1'b0;
      if (k < limit) check("stream_timeout", 64'(k), 64'(limit));
   endtask

   task automatic full_run(input int x, input int l, input int mode);
      int fc, tot;
      int wx0 = n_wx, wl0 = n_wl, b0 = n_b, p0 = n_p, x0 = n_x, r0 = n_rdy;
      tot = total_of(x, l);
      issue_start(x, l);
      stream(x, l, mode, tot, fc);
      @(posedge CLK); #1;
      check("w_count", 64'(n_wx - wx0), 64'(G*l*x));
      check("wl_count", 64'(n_wl - wl0), 64'(G*l));
      check("b_count", 64'(n_b - b0), 64'(G*l));
      check("p_count", 64'(n_p - p0), 64'(PEEP ? (G-1)*l : 0));
      check("x_count", 64'(n_x - x0), 64'(x));
      check("ready_count", 64'(n_rdy - r0), 64'd1);
      if (mode == 0) check("ready_latency", 64'(last_rdy_cyc - fc), 64'(tot));
      if (mode == 1) check("ready_latency_toggle", 64'(last_rdy_cyc - fc), 64'(2*(tot-1)+1));
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      check("in_ready_after_run", 64'(DATA_IN_READY), 64'd0);
   endtask

   initial begin
      int fc, r0, e0;
      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      check("reset_data_out", DATA_OUT, 64'd0);
      check("reset_ctrl", 64'({READY, ERROR, DATA_IN_READY, CHANNEL, W_OUT_X_ENABLE,
                               W_OUT_L_ENABLE, B_OUT_ENABLE, X_OUT_ENABLE, p_en}), 64'd0);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Directed run X=2 L=3, VALID high, then VALID toggling
      full_run(2, 3, 0);
      full_run(2, 3, 1);

      // Zero sizes rejected
      r0 = n_rdy; e0 = n_err;
      issue_start(2, 0);
      check("error_pulse_l0", 64'(ERROR), 64'd1);
      @(posedge CLK); #1;
      check("error_one_cycle", 64'(ERROR), 64'd0);
      check("in_ready_after_error", 64'(DATA_IN_READY), 64'd0);
      issue_start(0, 5);
      check("error_pulse_x0", 64'(ERROR), 64'd1);
      repeat (3) @(posedge CLK);
      #1;
      check("in_ready_idle", 64'(DATA_IN_READY), 64'd0);
      check("error_count", 64'(n_err - e0), 64'd2);
      check("no_ready_on_error", 64'(n_rdy - r0), 64'd0);

      // Reset mid-run after 10 weight transfers
      r0 = n_rdy;
      issue_start(2, 3);
      stream(2, 3, 0, 10, fc);
      RST = 1'b1;
      #1;
      check("midrun_reset_data_out", DATA_OUT, 64'd0);
      check("midrun_reset_ctrl", 64'({READY, ERROR, DATA_IN_READY, CHANNEL, W_OUT_X_ENABLE,
                                      W_OUT_L_ENABLE, B_OUT_ENABLE, X_OUT_ENABLE, p_en}), 64'd0);
      sb.delete();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("in_ready_needs_start", 64'(DATA_IN_READY), 64'd0);
      check("no_ready_after_abort", 64'(n_rdy - r0), 64'd0);
      full_run(2, 3, 0);

      // START held high across DONE: back-to-back runs, one READY each
      r0 = n_rdy;
      START = 1'b1; SIZE_X_IN = 64'd2; SIZE_L_IN = 64'd3;
      @(posedge CLK); #1;
      stream(2, 3, 0, 2*total_of(2, 3), fc);
      START = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("held_start_ready_count", 64'(n_rdy - r0), 64'd2);
      check("held_start_period", 64'(last_rdy_cyc - prev_rdy_cyc), 64'(total_of(2, 3) + 2));
      check("held_start_sb_empty", 64'(sb.size()), 64'd0);

      // Random sizes and random VALID
      for (int n = 0; n < 6; n++) begin
         full_run(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
